// File: rtl/counter_seek_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_seek_controller_if
// Purpose  : Bundles the request handshake and the step-command bus of the
//            counter seek controller.
//   slave  (controller side): takes iReqValid/iTarget/iAbort, drives the rest
//   master (command source / datapath side): the opposite directions
// Signals  : iReqValid, iTarget[W], iAbort, oReqReady, oStepEn, oSkip, oRev,
//            oPos[W], oBusy, oDone, oErr (names from the controller's view)
// Revision : 1.0 - initial release
// ============================================================================
interface counter_seek_controller_if #(
  parameter int W = 5
) ();
  logic         iReqValid;
  logic [W-1:0] iTarget;
  logic         iAbort;
  logic         oReqReady;
  logic         oStepEn;
  logic         oSkip;
  logic         oRev;
  logic [W-1:0] oPos;
  logic         oBusy;
  logic         oDone;
  logic         oErr;

  modport slave (
    input  iReqValid, iTarget, iAbort,
    output oReqReady, oStepEn, oSkip, oRev, oPos, oBusy, oDone, oErr
  );

  modport master (
    output iReqValid, iTarget, iAbort,
    input  oReqReady, oStepEn, oSkip, oRev, oPos, oBusy, oDone, oErr
  );
endinterface
`default_nettype wire

// File: rtl/counter_seek_controller.sv
`default_nettype none
// ============================================================================
// Module   : counter_seek_controller
// Purpose  : Walks an N_STATES skip/reverse ring counter to a requested target
//            by the fewest moves (+/-1 or +/-SKIP per cycle) and keeps a shadow
//            copy of the counter position.
// Ports    : iClk   - clock
//            iRst_n - asynchronous active-low reset
//            bus    - counter_seek_controller_if.slave (request handshake,
//                     abort, step commands, shadow position, status pulses)
// Revision : 1.0 - initial release
// ============================================================================
module counter_seek_controller #(
  parameter int N_STATES = 18,
  parameter int W        = 5,
  parameter int SKIP     = 3
) (
  input  wire logic                 iClk,
  input  wire logic                 iRst_n,
  counter_seek_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_t;

  // All ring arithmetic is done one bit wider than the position so that
  // sums such as 17+3 and differences such as 1-3 never alias.
  localparam logic [W:0] C_N    = (W+1)'(N_STATES);
  localparam logic [W:0] C_SKIP = (W+1)'(SKIP);
  localparam logic [W:0] C_HALF = (W+1)'(N_STATES / 2);
  localparam logic [W:0] C_ONE  = (W+1)'(1);

  state_t       rState;
  state_t       wNextState;
  logic [W-1:0] rPos;
  logic [W-1:0] rTarget;
  logic         rErr;

  logic         wAccept;
  logic         wReject;
  logic         wStepEn;
  logic         wSkip;
  logic         wRev;

  logic [W:0]   wPosX;
  logic [W:0]   wTgtX;
  logic [W:0]   wFwdDist;
  logic [W:0]   wRevDist;
  logic [W:0]   wAmt;
  logic [W:0]   wSum;
  logic [W-1:0] wFwdPos;
  logic [W-1:0] wRevPos;
  logic [W-1:0] wNextPos;

  assign wPosX    = {1'b0, rPos};
  assign wTgtX    = {1'b0, rTarget};
  assign wFwdDist = (wTgtX >= wPosX) ? (wTgtX - wPosX) : (wTgtX + C_N - wPosX);
  assign wRevDist = C_N - wFwdDist;

  assign wAmt     = wSkip ? C_SKIP : C_ONE;
  assign wSum     = wPosX + wAmt;
  assign wFwdPos  = (wSum >= C_N) ? W'(wSum - C_N) : wSum[W-1:0];
  assign wRevPos  = (wPosX >= wAmt) ? W'(wPosX - wAmt) : W'(wPosX + C_N - wAmt);
  assign wNextPos = wRev ? wRevPos : wFwdPos;

  // Next-state and step decode. Step commands depend only on registered
  // state, position and target; iAbort may only suppress a step.
  always_comb begin
    wNextState = rState;
    wAccept    = 1'b0;
    wReject    = 1'b0;
    wStepEn    = 1'b0;
    wSkip      = 1'b0;
    wRev       = 1'b0;
    case (rState)
      IDLE: begin
        if (bus.iReqValid) begin
          if ({1'b0, bus.iTarget} < C_N) begin
            wAccept    = 1'b1;
            wNextState = MOVE;
          end else begin
            wReject    = 1'b1;
          end
        end
      end
      MOVE: begin
        if (bus.iAbort) begin
          wNextState = IDLE;
        end else if (wFwdDist == '0) begin
          wNextState = DONE;
        end else begin
          wStepEn = 1'b1;
          // Equal distance both ways resolves to forward.
          if (wFwdDist <= C_HALF) begin
            wSkip = (wFwdDist >= C_SKIP);
          end else begin
            wRev  = 1'b1;
            wSkip = (wRevDist >= C_SKIP);
          end
        end
      end
      DONE: begin
        wNextState = IDLE;
      end
      default: begin
        wNextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rState  <= IDLE;
      rPos    <= '0;
      rTarget <= '0;
      rErr    <= 1'b0;
    end else begin
      rState <= wNextState;
      rErr   <= wReject;
      if (wAccept) begin
        rTarget <= bus.iTarget;
      end
      if (wStepEn) begin
        rPos <= wNextPos;
      end
    end
  end

  assign bus.oReqReady = (rState == IDLE);
  assign bus.oStepEn   = wStepEn;
  assign bus.oSkip     = wSkip;
  assign bus.oRev      = wRev;
  assign bus.oPos      = rPos;
  assign bus.oBusy     = (rState == MOVE) || (rState == DONE);
  assign bus.oDone     = (rState == DONE);
  assign bus.oErr      = rErr;

endmodule
`default_nettype wire

// File: tb/tb_counter_seek_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seek_controller
// Purpose  : Self-checking bench for counter_seek_controller. A ring model
//            tracks the counter position, judges every step command against
//            the shortest-path rule and scoreboards step counts and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seek_controller;

  localparam int N  = 18;
  localparam int SK = 3;

  logic iClk;
  logic iRst_n;

  counter_seek_controller_if #(.W(5)) bus ();

  counter_seek_controller #(
    .N_STATES (N),
    .W        (5),
    .SKIP     (SK)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nCmp      = 0;
  int nFail     = 0;
  int modelPos  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fwdDist(input int from, input int to);
    return ((to - from) % N + N) % N;
  endfunction

  function automatic int minSteps(input int from, input int to);
    int d;
    int k;
    d = fwdDist(from, to);
    k = (d < N - d) ? d : N - d;
    return k / SK + k % SK;
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (!bus.oReqReady && n < 50) begin
      tick();
      n++;
    end
    check("readyWait", 32'(bus.oReqReady), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_pos"},   32'(bus.oPos), 0);
    check({tag, "_ready"}, 32'(bus.oReqReady), 1);
    check({tag, "_step"},  32'(bus.oStepEn), 0);
    check({tag, "_skip"},  32'(bus.oSkip), 0);
    check({tag, "_rev"},   32'(bus.oRev), 0);
    check({tag, "_busy"},  32'(bus.oBusy), 0);
    check({tag, "_done"},  32'(bus.oDone), 0);
    check({tag, "_err"},   32'(bus.oErr), 0);
  endtask

  // Issue a request and follow it to oDone, judging each step against the
  // ring model. Random requests are thrown at the busy controller and must
  // have no effect.
  task automatic seek(input int tgt);
    int  mp;
    int  d;
    int  k;
    int  steps;
    int  cyc;
    int  expSteps;
    bit  done;
    bit  fwd;
    bit  expSkip;
    int  delta;
    mp       = modelPos;
    expSteps = minSteps(mp, tgt);
    steps    = 0;
    cyc      = 0;
    done     = 1'b0;
    waitReady();
    bus.iReqValid = 1'b1;
    bus.iTarget   = 5'(tgt);
    tick();
    bus.iReqValid = 1'b0;
    check("busyAfterAccept", 32'(bus.oBusy), 1);
    while (!done && cyc < 64) begin
      cyc++;
      if (bus.oDone) begin
        done = 1'b1;
        check("doneLatency", 32'(cyc), 32'(expSteps + 2));
        check("doneStepLow", 32'(bus.oStepEn), 0);
      end else if (bus.oStepEn) begin
        d   = fwdDist(mp, tgt);
        fwd = (d <= N / 2);
        k   = fwd ? d : N - d;
        expSkip = (k >= SK);
        check("stepNeeded", 32'(d != 0), 1);
        check("stepRev",  32'(bus.oRev),  32'(!fwd));
        check("stepSkip", 32'(bus.oSkip), 32'(expSkip));
        delta = (expSkip ? SK : 1) * (fwd ? 1 : -1);
        mp    = ((mp + delta) % N + N) % N;
        steps++;
      end else begin
        check("arrivedBeforeStop", 32'(fwdDist(mp, tgt)), 0);
        check("idleSkip", 32'(bus.oSkip), 0);
        check("idleRev",  32'(bus.oRev),  0);
      end
      if (!bus.oDone && $urandom_range(0, 3) == 0) begin
        bus.iReqValid = 1'b1;
        bus.iTarget   = 5'($urandom_range(0, 31));
      end else begin
        bus.iReqValid = 1'b0;
      end
      tick();
      bus.iReqValid = 1'b0;
      check("shadowPos", 32'(bus.oPos), 32'(mp));
    end
    check("doneSeen", 32'(done), 1);
    check("stepCount", 32'(steps), 32'(expSteps));
    check("finalPos", 32'(bus.oPos), 32'(tgt));
    check("readyAfterDone", 32'(bus.oReqReady), 1);
    modelPos = mp;
  endtask

  task automatic badReq(input int tgt);
    waitReady();
    bus.iReqValid = 1'b1;
    bus.iTarget   = 5'(tgt);
    check("errBefore", 32'(bus.oErr), 0);
    tick();
    bus.iReqValid = 1'b0;
    check("errPulse", 32'(bus.oErr), 1);
    check("errReady", 32'(bus.oReqReady), 1);
    check("errStep",  32'(bus.oStepEn), 0);
    check("errBusy",  32'(bus.oBusy), 0);
    check("errPos",   32'(bus.oPos), 32'(modelPos));
    tick();
    check("errClear", 32'(bus.oErr), 0);
    check("errPos2",  32'(bus.oPos), 32'(modelPos));
  endtask

  initial begin
    bus.iReqValid = 1'b0;
    bus.iTarget   = '0;
    bus.iAbort    = 1'b0;
    iRst_n        = 1'b0;
    #12;
    checkResetOutputs("reset");
    iRst_n = 1'b1;
    tick();
    checkResetOutputs("postReset");

    // Directed walks: 0->7, 7->0, tie 0->9, 9->9, rejects, wrap both ways.
    seek(7);
    seek(0);
    seek(9);
    seek(9);
    badReq(18);
    badReq(31);
    seek(1);
    seek(16);
    seek(2);

    // Abort one cycle after the first step of 0->8.
    seek(0);
    waitReady();
    bus.iReqValid = 1'b1;
    bus.iTarget   = 5'd8;
    tick();
    bus.iReqValid = 1'b0;
    check("abortFirstStep", 32'(bus.oStepEn), 1);
    check("abortFirstSkip", 32'(bus.oSkip), 1);
    check("abortFirstRev",  32'(bus.oRev), 0);
    tick();
    check("abortPosBefore", 32'(bus.oPos), 3);
    bus.iAbort = 1'b1;
    #1;
    check("abortGatesStep", 32'(bus.oStepEn), 0);
    check("abortGatesSkip", 32'(bus.oSkip), 0);
    tick();
    bus.iAbort = 1'b0;
    check("abortReady", 32'(bus.oReqReady), 1);
    check("abortBusy",  32'(bus.oBusy), 0);
    check("abortDone",  32'(bus.oDone), 0);
    check("abortPos",   32'(bus.oPos), 3);
    tick();
    check("abortNoDone", 32'(bus.oDone), 0);
    check("abortPosHold", 32'(bus.oPos), 3);
    modelPos = 3;

    // Reset in the middle of 3->12.
    waitReady();
    bus.iReqValid = 1'b1;
    bus.iTarget   = 5'd12;
    tick();
    bus.iReqValid = 1'b0;
    tick();
    check("midPos", 32'(bus.oPos), 6);
    iRst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(negedge iClk);
    iRst_n = 1'b1;
    tick();
    checkResetOutputs("afterMidReset");
    modelPos = 0;

    // Every (start, target) pair on the ring.
    for (int s = 0; s < N; s++) begin
      for (int t = 0; t < N; t++) begin
        seek(s);
        seek(t);
      end
    end

    // Random mix of legal and illegal requests.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        badReq($urandom_range(N, 31));
      end else begin
        seek($urandom_range(0, N - 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire
